// File: rtl/drink_vend_ctrl.sv
// drink_vend_ctrl: sequencing controller for the drink vending datapath.
// Collects coin credit in half-unit steps, requests a dispense once the price
// is met, then pays back change (or a full refund) one half-unit per hopper ack.
module drink_vend_ctrl #(
    parameter int PRICE_HALVES = 5,   // drink price in half-units, 1..12
    parameter int TIMEOUT      = 15   // coin-free COLLECT cycles before refund, 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       half,
    input  logic       one,
    input  logic       cancel,
    input  logic       dispense_ack,
    input  logic       change_ack,
    output logic       out,
    output logic       cout,
    output logic       coin_en,
    output logic [3:0] credit,
    output logic       busy
);

    localparam logic [3:0] PRICE      = 4'(PRICE_HALVES);
    localparam logic [7:0] TMO        = 8'(TIMEOUT);
    localparam logic [3:0] CREDIT_MAX = 4'(PRICE_HALVES + 2);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [3:0] credit_n;
    logic [7:0] tcnt, tcnt_n, tcnt_inc;
    logic       out_n, cout_n, coin_en_n, busy_n;

    // Coin decode: half is worth 1, one is worth 2, both together 3. The
    // acceptor is only honoured while we are in a coin-taking state.
    logic       accepting;
    logic       coin;
    logic [3:0] coin_val;
    logic [3:0] credit_sum;

    assign accepting  = (state == IDLE) || (state == COLLECT);
    assign coin       = accepting && (half || one);
    assign coin_val   = {2'b00, one, half};
    assign credit_sum = credit + coin_val;
    assign tcnt_inc   = tcnt + 8'd1;

    // State, credit, timeout counter and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            credit  <= 4'd0;
            tcnt    <= 8'd0;
            out     <= 1'b0;
            cout    <= 1'b0;
            coin_en <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            credit  <= credit_n;
            tcnt    <= tcnt_n;
            out     <= out_n;
            cout    <= cout_n;
            coin_en <= coin_en_n;
            busy    <= busy_n;
        end
    end

    // Next state, next credit and timeout count; coin beats cancel beats timeout.
    always_comb begin
        state_n  = state;
        credit_n = credit;
        tcnt_n   = 8'd0;
        case (state)
            IDLE: begin
                if (coin) begin
                    credit_n = credit_sum;
                    state_n  = (credit_sum >= PRICE) ? DISPENSE : COLLECT;
                end
            end
            COLLECT: begin
                if (coin) begin
                    credit_n = credit_sum;
                    if (credit_sum >= PRICE) state_n = DISPENSE;
                end else if (cancel) begin
                    state_n = CHANGE;
                end else if (tcnt_inc == TMO) begin
                    state_n = CHANGE;
                end else begin
                    tcnt_n = tcnt_inc;
                end
            end
            DISPENSE: begin
                if (dispense_ack) begin
                    credit_n = credit - PRICE;
                    state_n  = (credit == PRICE) ? IDLE : CHANGE;
                end
            end
            CHANGE: begin
                if (change_ack) begin
                    credit_n = credit - 4'd1;
                    if (credit == 4'd1) state_n = IDLE;
                end
            end
            default: begin
                state_n  = IDLE;
                credit_n = 4'd0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        out_n     = (state_n == DISPENSE);
        cout_n    = (state_n == CHANGE);
        coin_en_n = (state_n == IDLE) || (state_n == COLLECT);
        busy_n    = (state_n != IDLE);
    end

    // Credit can overshoot the price by at most one 3-half coin cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (credit <= CREDIT_MAX)
                else $error("credit above bound");
            assert (!(out && cout))
                else $error("dispense and change requested together");
        end
    end

endmodule

// File: tb/tb_drink_vend_ctrl.sv
// Scoreboard bench for drink_vend_ctrl: every stimulus cycle pushes the
// expected registered outputs, popped and compared after the clock edge.
module tb_drink_vend_ctrl;

    logic       clk = 1'b0;
    logic       reset, half, one, cancel, dispense_ack, change_ack;
    logic       out, cout, coin_en, busy;
    logic [3:0] credit;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic half, one, cancel, dack, cack, rst;
    } stim_t;

    typedef struct packed {
        logic [3:0] credit;
        logic       out, cout, coin_en, busy;
    } obs_t;

    obs_t sb[$];

    drink_vend_ctrl #(.PRICE_HALVES(5), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .half(half), .one(one), .cancel(cancel),
        .dispense_ack(dispense_ack), .change_ack(change_ack),
        .out(out), .cout(cout), .coin_en(coin_en), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stimulus constructors
    function automatic stim_t S(logic h, logic o, logic c, logic da, logic ca, logic r);
        return '{half:h, one:o, cancel:c, dack:da, cack:ca, rst:r};
    endfunction
    function automatic stim_t NOP();  return S(0,0,0,0,0,0); endfunction
    function automatic stim_t HALF(); return S(1,0,0,0,0,0); endfunction
    function automatic stim_t ONE();  return S(0,1,0,0,0,0); endfunction
    function automatic stim_t DACK(); return S(0,0,0,1,0,0); endfunction
    function automatic stim_t CACK(); return S(0,0,0,0,1,0); endfunction
    function automatic stim_t RST();  return S(0,0,0,0,0,1); endfunction

    // Expected-output constructors, one per FSM state
    function automatic obs_t E_IDLE();           return '{credit:4'd0, out:0, cout:0, coin_en:1, busy:0}; endfunction
    function automatic obs_t E_COL(logic [3:0] c); return '{credit:c, out:0, cout:0, coin_en:1, busy:1}; endfunction
    function automatic obs_t E_DSP(logic [3:0] c); return '{credit:c, out:1, cout:0, coin_en:0, busy:1}; endfunction
    function automatic obs_t E_CHG(logic [3:0] c); return '{credit:c, out:0, cout:1, coin_en:0, busy:1}; endfunction

    function automatic obs_t observed();
        return '{credit:credit, out:out, cout:cout, coin_en:coin_en, busy:busy};
    endfunction

    task automatic drive(input stim_t s);
        half = s.half; one = s.one; cancel = s.cancel;
        dispense_ack = s.dack; change_ack = s.cack; reset = s.rst;
    endtask

    task automatic test_reset();
        obs_t e, a;
        drive(RST());
        sb.push_back(E_IDLE());
        @(posedge clk); #1;
        e = sb.pop_front(); a = observed(); n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL test_reset: got %b want %b", a, e);
        end
        drive(NOP());
        sb.push_back(E_IDLE());
        @(posedge clk); #1;
        e = sb.pop_front(); a = observed(); n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL test_reset idle: got %b want %b", a, e);
        end
    endtask

    task automatic test_exact_price();
        stim_t sq[$]; obs_t a, e;
        sq = '{ONE(), ONE(), HALF(), NOP(), DACK(), NOP(), NOP()};
        sb.push_back(E_COL(2)); sb.push_back(E_COL(4)); sb.push_back(E_DSP(5));
        sb.push_back(E_DSP(5)); sb.push_back(E_IDLE()); sb.push_back(E_IDLE());
        sb.push_back(E_IDLE());
        foreach (sq[i]) begin
            drive(sq[i]); @(posedge clk); #1;
            e = sb.pop_front(); a = observed(); n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL test_exact_price[%0d]: got %b want %b", i, a, e);
            end
        end
    endtask

    task automatic test_change();
        stim_t sq[$]; obs_t a, e;
        sq = '{ONE(), ONE(), ONE(), DACK(), NOP(), CACK(), NOP()};
        sb.push_back(E_COL(2)); sb.push_back(E_COL(4)); sb.push_back(E_DSP(6));
        sb.push_back(E_CHG(1)); sb.push_back(E_CHG(1)); sb.push_back(E_IDLE());
        sb.push_back(E_IDLE());
        foreach (sq[i]) begin
            drive(sq[i]); @(posedge clk); #1;
            e = sb.pop_front(); a = observed(); n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL test_change[%0d]: got %b want %b", i, a, e);
            end
        end
    endtask

    task automatic test_both_coins();
        stim_t sq[$]; obs_t a, e;
        sq = '{HALF(), ONE(), S(1,1,0,0,0,0), HALF(), ONE(), DACK(), CACK()};
        sb.push_back(E_COL(1)); sb.push_back(E_COL(3)); sb.push_back(E_DSP(6));
        sb.push_back(E_DSP(6)); sb.push_back(E_DSP(6)); sb.push_back(E_CHG(1));
        sb.push_back(E_IDLE());
        foreach (sq[i]) begin
            drive(sq[i]); @(posedge clk); #1;
            e = sb.pop_front(); a = observed(); n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL test_both_coins[%0d]: got %b want %b", i, a, e);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t sq[$]; obs_t a, e;
        // First coin, then a coin mid-wait restarts the idle count.
        sq.push_back(ONE()); sb.push_back(E_COL(2));
        for (int k = 0; k < 10; k++) begin sq.push_back(NOP()); sb.push_back(E_COL(2)); end
        sq.push_back(HALF()); sb.push_back(E_COL(3));
        for (int k = 0; k < 14; k++) begin sq.push_back(NOP()); sb.push_back(E_COL(3)); end
        sq.push_back(NOP());  sb.push_back(E_CHG(3));
        sq.push_back(HALF()); sb.push_back(E_CHG(3));
        sq.push_back(CACK()); sb.push_back(E_CHG(2));
        sq.push_back(CACK()); sb.push_back(E_CHG(1));
        sq.push_back(CACK()); sb.push_back(E_IDLE());
        // Plain case: credit 2, fifteen silent cycles, two acks.
        sq.push_back(ONE()); sb.push_back(E_COL(2));
        for (int k = 0; k < 14; k++) begin sq.push_back(NOP()); sb.push_back(E_COL(2)); end
        sq.push_back(NOP());  sb.push_back(E_CHG(2));
        sq.push_back(CACK()); sb.push_back(E_CHG(1));
        sq.push_back(CACK()); sb.push_back(E_IDLE());
        foreach (sq[i]) begin
            drive(sq[i]); @(posedge clk); #1;
            e = sb.pop_front(); a = observed(); n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL test_timeout[%0d]: got %b want %b", i, a, e);
            end
        end
    endtask

    task automatic test_cancel();
        stim_t sq[$]; obs_t a, e;
        sq = '{HALF(), ONE(), S(0,0,1,0,0,0), CACK(), NOP(), CACK(), CACK(),
               ONE(), ONE(), S(1,0,1,0,0,0), DACK()};
        sb.push_back(E_COL(1)); sb.push_back(E_COL(3)); sb.push_back(E_CHG(3));
        sb.push_back(E_CHG(2)); sb.push_back(E_CHG(2)); sb.push_back(E_CHG(1));
        sb.push_back(E_IDLE());
        sb.push_back(E_COL(2)); sb.push_back(E_COL(4)); sb.push_back(E_DSP(5));
        sb.push_back(E_IDLE());
        foreach (sq[i]) begin
            drive(sq[i]); @(posedge clk); #1;
            e = sb.pop_front(); a = observed(); n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL test_cancel[%0d]: got %b want %b", i, a, e);
            end
        end
    endtask

    task automatic test_stray();
        stim_t sq[$]; obs_t a, e;
        sq = '{DACK(), CACK(), S(0,0,1,0,0,0), HALF(), S(0,0,0,1,1,0), RST()};
        sb.push_back(E_IDLE()); sb.push_back(E_IDLE()); sb.push_back(E_IDLE());
        sb.push_back(E_COL(1)); sb.push_back(E_COL(1)); sb.push_back(E_IDLE());
        foreach (sq[i]) begin
            drive(sq[i]); @(posedge clk); #1;
            e = sb.pop_front(); a = observed(); n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL test_stray[%0d]: got %b want %b", i, a, e);
            end
        end
    endtask

    task automatic test_reset_in_dispense();
        stim_t sq[$]; obs_t a, e;
        sq = '{ONE(), ONE(), ONE(), RST(), DACK(), NOP(), HALF(), RST()};
        sb.push_back(E_COL(2)); sb.push_back(E_COL(4)); sb.push_back(E_DSP(6));
        sb.push_back(E_IDLE()); sb.push_back(E_IDLE()); sb.push_back(E_IDLE());
        sb.push_back(E_COL(1)); sb.push_back(E_IDLE());
        foreach (sq[i]) begin
            drive(sq[i]); @(posedge clk); #1;
            e = sb.pop_front(); a = observed(); n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL test_reset_in_dispense[%0d]: got %b want %b", i, a, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t sq[$]; obs_t a, e;
        // Two purchases with no idle gap; fastest ack right after out rises.
        sq = '{S(1,1,0,0,0,0), ONE(), DACK(), ONE(), S(1,1,0,0,0,0), DACK(), CACK(), NOP()};
        sb.push_back(E_COL(3)); sb.push_back(E_DSP(5)); sb.push_back(E_IDLE());
        sb.push_back(E_COL(2)); sb.push_back(E_DSP(5)); sb.push_back(E_IDLE());
        sb.push_back(E_IDLE()); sb.push_back(E_IDLE());
        foreach (sq[i]) begin
            drive(sq[i]); @(posedge clk); #1;
            e = sb.pop_front(); a = observed(); n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL test_back_to_back[%0d]: got %b want %b", i, a, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_change();
        test_both_coins();
        test_timeout();
        test_cancel();
        test_stray();
        test_reset_in_dispense();
        test_back_to_back();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
